// File: rtl/regs_writeback.sv
// Write-back stage: merges a single-cycle ALU result stream with buffered
// memory/load results and drives the register file write port. The ALU has
// priority. Memory results wait in an in-order FIFO and drain on cycles when
// the ALU is not writing. query_hit reports a still-queued load destination.
module regs_writeback #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_in,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [XLEN-1:0]            alu_value,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_rd,
    input  logic [XLEN-1:0]            mem_value,
    input  logic [ADDR_W-1:0]          query_rd,
    output logic                       query_hit,
    output logic [ADDR_W-1:0]          rd_out,
    output logic                       rd_write_out,
    output logic [XLEN-1:0]            rd_value_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_rd  [DEPTH];
    logic [XLEN-1:0]   fifo_val [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic alu_wins;
    logic push;
    logic pop;

    // Full is judged from the registered count only, so a same-cycle pop
    // never opens room for a push.
    assign mem_ready = (count != CNT_W'(DEPTH));
    assign count_out = count;

    // Port arbitration: an ALU write to rd 0 does not claim the port.
    always_comb begin
        alu_wins = alu_valid && (alu_rd != '0);
        push     = mem_valid && mem_ready && !flush_in && (mem_rd != '0);
        pop      = !alu_wins && (count != '0) && !flush_in;
    end

    // Pending-load lookup across the occupied FIFO slots only.
    always_comb begin
        logic [PTR_W-1:0] idx;
        query_hit = 1'b0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (fifo_rd[idx] == query_rd))
                query_hit = 1'b1;
        end
        if (query_rd == '0)
            query_hit = 1'b0;
    end

    // FIFO payload storage; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]  <= mem_rd;
            fifo_val[wr_ptr] <= mem_value;
        end
    end

    // FIFO pointers and occupancy; flush empties the queue on the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port; rd/value hold their last value between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_out       <= '0;
            rd_value_out <= '0;
            rd_write_out <= 1'b0;
        end else begin
            rd_write_out <= alu_wins || pop;
            if (alu_wins) begin
                rd_out       <= alu_rd;
                rd_value_out <= alu_value;
            end else if (pop) begin
                rd_out       <= fifo_rd[rd_ptr];
                rd_value_out <= fifo_val[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_regs_writeback.sv
// Scoreboard bench for regs_writeback: the driver keeps a queue-based model of
// the pending loads and pushes one expected write-port result per cycle; the
// monitor pops and compares on every falling edge.
module tb_regs_writeback;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 4;

    typedef struct {
        bit               w;
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   val;
    } wr_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               flush_in = 1'b0;
    logic               alu_valid = 1'b0;
    logic [ADDR_W-1:0]  alu_rd = '0;
    logic [XLEN-1:0]    alu_value = '0;
    logic               mem_valid = 1'b0;
    logic               mem_ready;
    logic [ADDR_W-1:0]  mem_rd = '0;
    logic [XLEN-1:0]    mem_value = '0;
    logic [ADDR_W-1:0]  query_rd = '0;
    logic               query_hit;
    logic [ADDR_W-1:0]  rd_out;
    logic               rd_write_out;
    logic [XLEN-1:0]    rd_value_out;
    logic [$clog2(DEPTH):0] count_out;

    int checks = 0;
    int failures = 0;

    wr_t exp_q[$];
    wr_t pend_q[$];
    logic [ADDR_W-1:0] last_rd = '0;
    logic [XLEN-1:0]   last_val = '0;

    regs_writeback #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush_in(flush_in),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
        .mem_value(mem_value), .query_rd(query_rd), .query_hit(query_hit),
        .rd_out(rd_out), .rd_write_out(rd_write_out),
        .rd_value_out(rd_value_out), .count_out(count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pending(input logic [ADDR_W-1:0] r);
        if (r == '0) return 1'b0;
        foreach (pend_q[i]) if (pend_q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: compare the write port against the next scoreboard entry.
    always @(negedge clk) begin
        wr_t e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{w: 1'b0, rd: '0, val: '0};
        chk("wr_en", rd_write_out, e.w);
        if (e.w) begin
            chk("wr_rd", rd_out, e.rd);
            chk("wr_val", rd_value_out, e.val);
            last_rd = e.rd;
            last_val = e.val;
        end else begin
            chk("hold_rd", rd_out, last_rd);
            chk("hold_val", rd_value_out, last_val);
        end
    end

    // One clock cycle of stimulus; model is advanced with the rules of the stage.
    task automatic cyc(input bit av, input logic [ADDR_W-1:0] ard, input logic [XLEN-1:0] aval,
                       input bit mv, input logic [ADDR_W-1:0] mrd, input logic [XLEN-1:0] mval,
                       input bit fl, input logic [ADDR_W-1:0] qrd);
        bit ready_m;
        wr_t e;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_value = aval;
        mem_valid = mv; mem_rd = mrd; mem_value = mval;
        flush_in = fl; query_rd = qrd;
        #1;
        ready_m = (pend_q.size() != DEPTH);
        chk("count", count_out, pend_q.size());
        chk("ready", mem_ready, ready_m);
        chk("query_hit", query_hit, pending(qrd));
        if (av && ard != '0) chk("waw_guard", pending(ard), 0);
        e = '{w: 1'b0, rd: '0, val: '0};
        if (av && ard != '0) e = '{w: 1'b1, rd: ard, val: aval};
        else if (pend_q.size() > 0 && !fl) e = pend_q.pop_front();
        exp_q.push_back(e);
        if (fl) pend_q.delete();
        else if (mv && ready_m && mrd != '0) pend_q.push_back('{w: 1'b1, rd: mrd, val: mval});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(10);
        chk("t1_wr", rd_write_out, 0);
        chk("t1_count", count_out, 0);
        chk("t1_ready", mem_ready, 1);

        // Single ALU write
        cyc(1, 5, 64'h1234, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_wr", rd_write_out, 1);
        chk("t2_rd", rd_out, 5);
        chk("t2_val", rd_value_out, 64'h1234);

        // Fill FIFO behind a busy ALU, then drain in order
        for (int i = 1; i <= 4; i++) cyc(1, 7, 64'h70 + i, 1, ADDR_W'(i), 64'h9 + i, 0, 0);
        cyc(1, 7, 64'h77, 0, 0, 0, 0, 3);
        chk("t3_count", count_out, 4);
        chk("t3_ready", mem_ready, 0);
        chk("t3_hit", query_hit, 1);
        cyc(1, 7, 64'h78, 1, 6, 64'hEE, 0, 0);   // full: offered push is refused
        idle(5);
        chk("t3_empty", count_out, 0);

        // Simultaneous push and pop keeps occupancy
        cyc(1, 7, 1, 1, 11, 64'hB1, 0, 0);
        cyc(1, 7, 2, 1, 12, 64'hB2, 0, 0);
        cyc(0, 0, 0, 1, 13, 64'hB3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_count", count_out, 2);
        chk("t4_wr", rd_write_out, 1);
        chk("t4_rd", rd_out, 11);
        idle(4);

        // Flush with concurrent ALU write and push, then rd 0 load
        for (int i = 2; i <= 4; i++) cyc(1, 7, 3, 1, ADDR_W'(i), 64'hC0 + i, 0, 0);
        cyc(1, 9, 64'h99, 1, 5, 64'h55, 1, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 3);
        chk("t5_count", count_out, 0);
        chk("t5_hit", query_hit, 0);
        chk("t5_rd", rd_out, 9);
        cyc(0, 0, 0, 1, 0, 64'hDEAD, 0, 0);
        chk("t5_nopop", rd_write_out, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_rd0_count", count_out, 0);
        idle(2);

        // Async reset between edges with FIFO holding 3
        for (int i = 2; i <= 4; i++) cyc(1, 7, 4, 1, ADDR_W'(i), 64'hD0 + i, 0, 0);
        @(negedge clk);
        alu_valid = 0; mem_valid = 0; flush_in = 0; query_rd = 0;
        #2 reset = 1'b1;
        #1;
        chk("t6_wr", rd_write_out, 0);
        chk("t6_rd", rd_out, 0);
        chk("t6_val", rd_value_out, 0);
        chk("t6_count", count_out, 0);
        chk("t6_ready", mem_ready, 1);
        pend_q.delete();
        exp_q.delete();
        last_rd = '0;
        last_val = '0;
        @(negedge clk);
        #1 reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit av, mv, fl;
            logic [ADDR_W-1:0] ard, mrd, qrd;
            av  = ($urandom_range(0, 9) < 4);
            ard = ADDR_W'($urandom_range(0, 15));
            if (pending(ard)) av = 1'b0;
            mv  = ($urandom_range(0, 1) == 1);
            mrd = ADDR_W'($urandom_range(0, 15));
            fl  = ($urandom_range(0, 19) == 0);
            qrd = ADDR_W'($urandom_range(0, 15));
            cyc(av, ard, {$urandom, $urandom}, mv, mrd, {$urandom, $urandom}, fl, qrd);
        end
        idle(DEPTH + 2);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
